l1_wb_arbiter: RTL
==================

// Module: l1_wb_arbiter
// PURPOSE
//  N-channel arbiter merging L1 cache miss/store traffic (ch0=L1I, ch1=L1D, more for
//  future prefetch/uncached ports) onto one Wishbone B4 pipelined master port.
//  Round-robin grant, up to MAX_OUTST beats in flight, in-order responses routed back
//  to the issuing channel via an ID FIFO. Sits between l1 caches and the system bus.
// PARAMETERS
//  N_CH       2   number of requesting channels (1..8)
//  AW         32  address width
//  DW         32  data width (multiple of 8)
//  MAX_OUTST  4   max issued-but-unacknowledged beats (power of 2, >=1)
//  TIMEOUT_CYC 256 ack watchdog limit (used only with L1_WB_TIMEOUT_EN)
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous reset, active-high
//  ch_req_val   in   N_CH       per-channel request valid
//  ch_req_we    in   N_CH       1=write, 0=read
//  ch_req_addr  in   N_CH*AW    request address, channel i at [i*AW +: AW]
//  ch_req_wdata in   N_CH*DW    write data
//  ch_req_sel   in   N_CH*DW/8  byte enables
//  ch_req_rdy   out  N_CH       request accepted this cycle (one-hot or zero)
//  ch_rsp_val   out  N_CH       response valid, one-hot, 1-cycle pulse
//  ch_rsp_data  out  DW         read data (shared; qualify with ch_rsp_val)
//  ch_rsp_err   out  1          response carries bus error/timeout
//  wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o  out  AW/DW/DW/8/1  registered beat fields
//  wb_cyc_o, wb_stb_o  out 1    bus cycle / strobe, registered
//  wb_tgc_o     out  3          channel id of beat on bus
//  wb_dat_i in DW; wb_ack_i, wb_err_i, wb_stall_i  in 1
//  proto_err    out  1          sticky: ack/err received with no beat outstanding
// BEHAVIOUR
//  Reset: all outputs 0, rr pointer=0, FIFO empty, FSM IDLE; mid-op reset drops cyc
//   asynchronously, in-flight beats discarded, no responses emitted.
//  Accept: slot_free = !wb_stb_o | !wb_stall_i; accept when slot_free & any val &
//   (outst_cnt + stb_pending) < MAX_OUTST & state!=FLUSH. Grant = first valid at or
//   after rr_ptr (wrapping); rr_ptr <- grant+1 mod N_CH. rdy to that channel same cycle.
//  Issue: accepted fields register onto wb_* next cycle, wb_stb_o=1; held stable
//   while wb_stall_i=1. Beat issued when stb & !stall -> channel id pushed to FIFO.
//  Completion: ack_i or err_i pops FIFO head; next cycle ch_rsp_val[head]=1,
//   ch_rsp_data=registered wb_dat_i, ch_rsp_err=err_i. ack and err together = err.
//  Push+pop same cycle: count unchanged. ack with empty FIFO: ignored, proto_err=1.
//  FSM IDLE->BUS on first accept (cyc_o=1 with stb_o). BUS->IDLE when FIFO empties and
//   no stb pending/accept that cycle (cyc_o falls next cycle). Back-to-back allowed.
//  Write responses: ch_rsp_val pulses, data undefined (0).
//  Latency: request->stb 1 cycle; ack->rsp 1 cycle; min read round trip 3 cycles.
// CONFIGURATION
//  L1_WB_TIMEOUT_EN defined: counter clears on ack/err/issue, counts while FIFO
//   non-empty; at TIMEOUT_CYC -> state FLUSH: cyc_o/stb_o drop, no accepts, each
//   FIFO entry emits ch_rsp_err=1 response one per cycle in order, then IDLE.
//   Late acks in FLUSH/IDLE set proto_err. Undefined: no counter, no FLUSH state.
// STRUCTURE
//  l1_wb_arb_pkg: state enum (IDLE/BUS/FLUSH), CH_IDW=$clog2(N_CH) helper,
//   beat struct {we, addr, wdata, sel, id}.
//  Sub-module l1_wb_id_fifo: MAX_OUTST-deep id FIFO, push/pop/full/empty/count.
// TESTING
//  1 read ch0 addr 0x100, ack 2 cycles after stb, dat_i=0xCAFE -> rsp_val=01, data 0xCAFE.
//  2 ch0,ch1 val every cycle, no stall -> grants alternate 0,1,0,1; tgc matches order.
//  3 4 reads issued, stall=1 for 5 cycles on 2nd beat -> adr held, 5th req rdy=0
//    until first ack; responses in issue order.
//  4 write ch1 sel=0x3, err_i on ack -> rsp_val=10, rsp_err=1; cyc drops after.
//  5 ack with no outstanding -> proto_err=1 sticky until rst; rst mid-burst -> cyc=0.
//  6 (L1_WB_TIMEOUT_EN, TIMEOUT_CYC=16) 3 beats, no ack -> cycle 16 cyc=0, 3 err rsps.

Source files
------------

// File: rtl/l1_wb_arb_pkg.sv
// Shared types for the L1 Wishbone arbiter: FSM states, issued-beat payload and width helpers.
package l1_wb_arb_pkg;

   localparam int unsigned BEAT_AW = 32;
   localparam int unsigned BEAT_DW = 32;
   localparam int unsigned BEAT_SW = BEAT_DW / 8;
   localparam int unsigned TGC_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUS   = 2'd1,
      ST_FLUSH = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic               we;
      logic [BEAT_AW-1:0] addr;
      logic [BEAT_DW-1:0] wdata;
      logic [BEAT_SW-1:0] sel;
      logic [TGC_W-1:0]   id;
   } beat_t;

   function automatic int unsigned ch_idw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned d);
      return $clog2(d) + 1;
   endfunction

endpackage

// File: rtl/l1_wb_id_fifo.sv
// In-order FIFO of channel ids for beats issued on the bus and not yet acknowledged.
module l1_wb_id_fifo
   import l1_wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDW   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic [IDW-1:0]            push_id,
   input  logic                      pop,
   output logic [IDW-1:0]            head_id,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0] mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head_id = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

   // Pointers wrap explicitly so non-power-of-2 depths stay correct.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/l1_wb_arbiter.sv
// Round-robin merge of N L1 request channels onto one Wishbone B4 pipelined master.
// Optional ack watchdog with error flush is built when L1_WB_TIMEOUT_EN is defined.
module l1_wb_arbiter
   import l1_wb_arb_pkg::*;
#(
   parameter int unsigned N_CH        = 2,
   parameter int unsigned AW          = 32,
   parameter int unsigned DW          = 32,
   parameter int unsigned MAX_OUTST   = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        ch_req_val,
   input  logic [N_CH-1:0]        ch_req_we,
   input  logic [N_CH*AW-1:0]     ch_req_addr,
   input  logic [N_CH*DW-1:0]     ch_req_wdata,
   input  logic [N_CH*DW/8-1:0]   ch_req_sel,
   output logic [N_CH-1:0]        ch_req_rdy,
   output logic [N_CH-1:0]        ch_rsp_val,
   output logic [DW-1:0]          ch_rsp_data,
   output logic                   ch_rsp_err,
   output logic [AW-1:0]          wb_adr_o,
   output logic [DW-1:0]          wb_dat_o,
   output logic [DW/8-1:0]        wb_sel_o,
   output logic                   wb_we_o,
   output logic                   wb_cyc_o,
   output logic                   wb_stb_o,
   output logic [2:0]             wb_tgc_o,
   input  logic [DW-1:0]          wb_dat_i,
   input  logic                   wb_ack_i,
   input  logic                   wb_err_i,
   input  logic                   wb_stall_i,
   output logic                   proto_err
);

   localparam int unsigned IDW = ch_idw(N_CH);
   localparam int unsigned CW  = cnt_w(MAX_OUTST);
   localparam int unsigned SW  = DW / 8;

   if (N_CH < 1 || N_CH > 8 || AW > BEAT_AW || DW > BEAT_DW || (DW % 8) != 0 ||
       MAX_OUTST < 1 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_bad_cfg
      $error("l1_wb_arbiter: unsupported parameter set");
   end

   arb_state_e     state;
   beat_t          beat_q;
   beat_t          beat_c;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] grant_c;
   logic [IDW-1:0] rr_next_c;
   logic           found_c;
   int unsigned    idx;
   logic           accept_c;
   logic           push_c;
   logic           pop_c;
   logic           rsp_in_c;
   logic           flushing_c;
   logic           timeout_c;
   logic [IDW-1:0] fifo_head;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  fifo_cnt;

   // First valid channel at or after rr_ptr, wrapping.
   always_comb begin
      grant_c = '0;
      found_c = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         idx = (32'(rr_ptr) + i) % N_CH;
         if (!found_c && ch_req_val[IDW'(idx)]) begin
            found_c = 1'b1;
            grant_c = IDW'(idx);
         end
      end
   end

   assign rr_next_c  = (32'(grant_c) + 32'd1 == N_CH) ? '0 : grant_c + IDW'(1);
   assign rsp_in_c   = wb_ack_i | wb_err_i;
   assign flushing_c = (state == ST_FLUSH);
   assign push_c     = wb_stb_o & ~wb_stall_i;
   assign pop_c      = ~fifo_empty & ((state == ST_BUS & rsp_in_c) | flushing_c);
   assign accept_c   = (~wb_stb_o | ~wb_stall_i) & found_c & ~fifo_full & ~flushing_c & ~timeout_c &
                       ((32'(fifo_cnt) + 32'(wb_stb_o)) < MAX_OUTST);
   assign ch_req_rdy = accept_c ? (N_CH'(1) << grant_c) : '0;

   always_comb begin
      beat_c       = '0;
      beat_c.we    = ch_req_we[grant_c];
      beat_c.addr  = BEAT_AW'(ch_req_addr[grant_c*AW +: AW]);
      beat_c.wdata = BEAT_DW'(ch_req_wdata[grant_c*DW +: DW]);
      beat_c.sel   = BEAT_SW'(ch_req_sel[grant_c*SW +: SW]);
      beat_c.id    = TGC_W'(grant_c);
   end

   assign wb_adr_o = AW'(beat_q.addr);
   assign wb_dat_o = DW'(beat_q.wdata);
   assign wb_sel_o = SW'(beat_q.sel);
   assign wb_we_o  = beat_q.we;
   assign wb_tgc_o = beat_q.id;

   l1_wb_id_fifo #(.DEPTH(MAX_OUTST), .IDW(IDW)) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push_c),
      .push_id (IDW'(beat_q.id)),
      .pop     (pop_c),
      .head_id (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

`ifdef L1_WB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;

   assign timeout_c = (state == ST_BUS) & ~fifo_empty & ~rsp_in_c & ~push_c &
                      (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) to_cnt <= '0;
      else     to_cnt <= (rsp_in_c || push_c || fifo_empty) ? '0 : to_cnt + TW'(1);
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Beat register, response path and bus-cycle FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rr_ptr      <= '0;
         beat_q      <= '0;
         wb_stb_o    <= 1'b0;
         wb_cyc_o    <= 1'b0;
         ch_rsp_val  <= '0;
         ch_rsp_data <= '0;
         ch_rsp_err  <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         ch_rsp_val <= '0;
         ch_rsp_err <= 1'b0;
         if (pop_c) begin
            ch_rsp_val  <= N_CH'(1) << fifo_head;
            ch_rsp_data <= flushing_c ? '0 : wb_dat_i;
            ch_rsp_err  <= flushing_c | wb_err_i;
         end
         if (rsp_in_c && !(state == ST_BUS && !fifo_empty)) proto_err <= 1'b1;

         if (accept_c) begin
            beat_q   <= beat_c;
            wb_stb_o <= 1'b1;
            rr_ptr   <= rr_next_c;
         end else if (push_c) begin
            wb_stb_o <= 1'b0;
         end

         unique case (state)
            ST_IDLE: begin
               if (accept_c) begin
                  state    <= ST_BUS;
                  wb_cyc_o <= 1'b1;
               end
            end
            ST_BUS: begin
               if (timeout_c) begin
                  state    <= ST_FLUSH;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
               end else if (!accept_c && !wb_stb_o &&
                            (fifo_cnt == '0 || (fifo_cnt == CW'(1) && pop_c))) begin
                  state    <= ST_IDLE;
                  wb_cyc_o <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (fifo_cnt <= CW'(1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
